// File: rtl/arm_imm_encoder.sv
// ---------------------------------------------------------------------------
// arm_imm_encoder
//
// Iterative inverse of the shifter IMMED path. Given a 32-bit constant it
// searches for immed_8 / rotate_imm such that
//   value == ror(immed_8, 2*rotate_imm)
// testing one rotation per cycle. When ENABLE_INV is set it also searches
// for an encoding of ~value so the decoder can substitute MVN/BIC.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds in_value while in_valid
// is high; the result is held stable with out_valid high until out_ready.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    request valid
//   in_ready    request can be accepted (high only in IDLE)
//   in_value    32-bit constant to encode
//   out_valid   result valid, held until out_ready
//   out_ready   consumer accepts the result
//   res_found   an encoding exists (positive or inverted)
//   res_inv     encoding is of ~in_value
//   res_imm8    immed_8 field
//   res_rot     rotate_imm field
//   res_c_keep  1 when the shifter carry is the C flag (found and rot==0)
//   dbg_state_o current FSM state (0=IDLE, 1=SEARCH, 2=DONE)
// ---------------------------------------------------------------------------
module arm_imm_encoder #(
    parameter bit ENABLE_INV = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        res_found,
    output logic        res_inv,
    output logic [7:0]  res_imm8,
    output logic [3:0]  res_rot,
    output logic        res_c_keep,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] w_pos_q, w_neg_q;
    logic [3:0]  r_q;
    logic        pos_hit_q, neg_hit_q;
    logic [7:0]  pos_imm8_q, neg_imm8_q;
    logic [3:0]  pos_rot_q, neg_rot_q;
    logic        out_valid_q;
    logic        res_found_q, res_inv_q, res_c_keep_q;
    logic [7:0]  res_imm8_q;
    logic [3:0]  res_rot_q;

    // Hit detection on the current rotation window.
    logic       pos_now, neg_now, last_rot, finish;
    // Best candidates including the rotation evaluated this cycle.
    logic       pos_any, neg_any;
    logic [7:0] pos_imm8_sel, neg_imm8_sel;
    logic [3:0] pos_rot_sel, neg_rot_sel;
    // Result computed at the finishing edge.
    logic       res_found_d, res_inv_d, res_c_keep_d;
    logic [7:0] res_imm8_d;
    logic [3:0] res_rot_d;

    always_comb begin
        pos_now  = (w_pos_q[31:8] == 24'd0);
        neg_now  = ENABLE_INV && (w_neg_q[31:8] == 24'd0);
        last_rot = (r_q == 4'd15);
        // Exit at r=15 always wins, so the counter wrap is never observed.
        finish   = (state_q == S_SEARCH) && ((EARLY_EXIT && pos_now) || last_rot);

        // The earliest hit wins: a latched hit beats the current one.
        pos_any      = pos_hit_q || pos_now;
        pos_imm8_sel = pos_hit_q ? pos_imm8_q : w_pos_q[7:0];
        pos_rot_sel  = pos_hit_q ? pos_rot_q  : r_q;
        neg_any      = neg_hit_q || neg_now;
        neg_imm8_sel = neg_hit_q ? neg_imm8_q : w_neg_q[7:0];
        neg_rot_sel  = neg_hit_q ? neg_rot_q  : r_q;

        res_found_d = 1'b0;
        res_inv_d   = 1'b0;
        res_imm8_d  = 8'd0;
        res_rot_d   = 4'd0;
        // Positive encoding always has priority over the inverted one.
        if (pos_any) begin
            res_found_d = 1'b1;
            res_imm8_d  = pos_imm8_sel;
            res_rot_d   = pos_rot_sel;
        end else if (neg_any) begin
            res_found_d = 1'b1;
            res_inv_d   = 1'b1;
            res_imm8_d  = neg_imm8_sel;
            res_rot_d   = neg_rot_sel;
        end
        res_c_keep_d = res_found_d && (res_rot_d == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            w_pos_q      <= 32'd0;
            w_neg_q      <= 32'd0;
            r_q          <= 4'd0;
            pos_hit_q    <= 1'b0;
            neg_hit_q    <= 1'b0;
            pos_imm8_q   <= 8'd0;
            pos_rot_q    <= 4'd0;
            neg_imm8_q   <= 8'd0;
            neg_rot_q    <= 4'd0;
            out_valid_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_inv_q    <= 1'b0;
            res_imm8_q   <= 8'd0;
            res_rot_q    <= 4'd0;
            res_c_keep_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_pos_q   <= in_value;
                        w_neg_q   <= ~in_value;
                        r_q       <= 4'd0;
                        pos_hit_q <= 1'b0;
                        neg_hit_q <= 1'b0;
                        state_q   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (pos_now && !pos_hit_q) begin
                        pos_hit_q  <= 1'b1;
                        pos_imm8_q <= w_pos_q[7:0];
                        pos_rot_q  <= r_q;
                    end
                    if (neg_now && !neg_hit_q) begin
                        neg_hit_q  <= 1'b1;
                        neg_imm8_q <= w_neg_q[7:0];
                        neg_rot_q  <= r_q;
                    end
                    if (finish) begin
                        state_q      <= S_DONE;
                        out_valid_q  <= 1'b1;
                        res_found_q  <= res_found_d;
                        res_inv_q    <= res_inv_d;
                        res_imm8_q   <= res_imm8_d;
                        res_rot_q    <= res_rot_d;
                        res_c_keep_q <= res_c_keep_d;
                    end else begin
                        // Rotating left by 2 walks the window through ror(value, 2r).
                        w_pos_q <= {w_pos_q[29:0], w_pos_q[31:30]};
                        w_neg_q <= {w_neg_q[29:0], w_neg_q[31:30]};
                        r_q     <= r_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign res_found   = res_found_q;
    assign res_inv     = res_inv_q;
    assign res_imm8    = res_imm8_q;
    assign res_rot     = res_rot_q;
    assign res_c_keep  = res_c_keep_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
module tb_arm_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;

    logic        in_ready, out_valid, res_found, res_inv, res_c_keep;
    logic [7:0]  res_imm8;
    logic [3:0]  res_rot;
    logic [1:0]  dbg_state;

    logic        ni_in_ready, ni_out_valid, ni_found, ni_inv, ni_c_keep;
    logic [7:0]  ni_imm8;
    logic [3:0]  ni_rot;
    logic [1:0]  ni_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    arm_imm_encoder #(.ENABLE_INV(1'b1), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_found(res_found), .res_inv(res_inv), .res_imm8(res_imm8),
        .res_rot(res_rot), .res_c_keep(res_c_keep), .dbg_state_o(dbg_state)
    );

    // Same stimulus, inverted search disabled.
    arm_imm_encoder #(.ENABLE_INV(1'b0), .EARLY_EXIT(1'b1)) dut_noinv (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ni_in_ready), .in_value(in_value),
        .out_valid(ni_out_valid), .out_ready(out_ready),
        .res_found(ni_found), .res_inv(ni_inv), .res_imm8(ni_imm8),
        .res_rot(ni_rot), .res_c_keep(ni_c_keep), .dbg_state_o(ni_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency in edges after E0, check all result fields.
    task automatic run_req(input string tag, input logic [31:0] v, input int exp_lat,
                           input logic f, input logic inv, input logic [7:0] imm,
                           input logic [3:0] rot, input logic ck);
        int lat;
        logic nf;
        @(negedge clk);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);              // E0
        #1;
        in_valid = 1'b0;
        in_value = $urandom;         // must be ignored after acceptance
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " found"}, {31'd0, res_found}, {31'd0, f});
        check({tag, " inv"}, {31'd0, res_inv}, {31'd0, inv});
        check({tag, " imm8"}, {24'd0, res_imm8}, {24'd0, imm});
        check({tag, " rot"}, {28'd0, res_rot}, {28'd0, rot});
        check({tag, " c_keep"}, {31'd0, res_c_keep}, {31'd0, ck});
        // Without inverted search, an inverted-only result becomes not-found.
        nf = f && !inv;
        check({tag, " noinv valid"}, {31'd0, ni_out_valid}, 32'd1);
        check({tag, " noinv found"}, {31'd0, ni_found}, {31'd0, nf});
        check({tag, " noinv fields"}, {18'd0, ni_inv, ni_imm8, ni_rot, ni_c_keep},
              nf ? {18'd0, 1'b0, imm, rot, ck} : 32'd0);
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, {31'd0, out_valid}, 32'd0);
        check({tag, " back to idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] hold_imm;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset res", {18'd0, res_found, res_inv, res_imm8, res_rot, res_c_keep}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_req("zero",     32'h0000_0000,  1, 1'b1, 1'b0, 8'h00, 4'd0,  1'b1); release_res("zero");
        run_req("ff_top",   32'hFF00_0000,  5, 1'b1, 1'b0, 8'hFF, 4'd4,  1'b0); release_res("ff_top");
        run_req("f_wrap",   32'hF000_000F,  3, 1'b1, 1'b0, 8'hFF, 4'd2,  1'b0); release_res("f_wrap");
        run_req("ab",       32'h0000_00AB,  1, 1'b1, 1'b0, 8'hAB, 4'd0,  1'b1); release_res("ab");
        run_req("bit_wrap", 32'h8000_0001,  2, 1'b1, 1'b0, 8'h06, 4'd1,  1'b0); release_res("bit_wrap");
        run_req("rot15",    32'h0000_03FC, 16, 1'b1, 1'b0, 8'hFF, 4'd15, 1'b0); release_res("rot15");
        run_req("all_ones", 32'hFFFF_FFFF, 16, 1'b1, 1'b1, 8'h00, 4'd0,  1'b1); release_res("all_ones");
        run_req("inv_ff",   32'hFFFF_FF00, 16, 1'b1, 1'b1, 8'hFF, 4'd0,  1'b1); release_res("inv_ff");

        // Not found, then hold the result with out_ready low and in_valid high.
        run_req("none", 32'h0000_0101, 16, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        in_valid = 1'b1;
        in_value = 32'h0000_0000;
        hold_imm = res_imm8;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold res", {18'd0, res_found, res_inv, res_imm8, res_rot, res_c_keep}, 32'd0);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("hold imm stable", {24'd0, res_imm8}, {24'd0, hold_imm});
        in_valid = 1'b0;
        release_res("none");

        // Asynchronous reset in the middle of a search (r=7).
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'h0000_03FC;
        @(posedge clk);              // E0
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);   // r_q now 7
        #3;
        check("mid search state", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        #1;
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post rst in_ready", {31'd0, in_ready}, 32'd1);
        check("post rst out_valid", {31'd0, out_valid}, 32'd0);
        run_req("after_rst", 32'hFF00_0000, 5, 1'b1, 1'b0, 8'hFF, 4'd4, 1'b0);
        release_res("after_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
